vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Arbitrates one single-port synchronous framebuffer RAM between VGA scanout and a CPU port.
//  Scanout owns one fixed RAM slot per PIX_PER_WORD pixels during active video and always wins.
//  The CPU port gets every other cycle through a req/ack handshake.
//  Sits between the VGA timing generator (hcount/vcount) and the framebuffer RAM.
//  Emits serialised pixels plus a vblank-start pulse.
// PARAMETERS
//  H_ACTIVE      640  visible pixels per line (multiple of PIX_PER_WORD)
//  V_ACTIVE      480  visible lines per frame
//  BPP           2    bits per pixel
//  PIX_PER_WORD  4    pixels per RAM word (power of 2); DATA_W = BPP*PIX_PER_WORD
//  ADDR_W        17   RAM word address width; FB_WORDS = H_ACTIVE*V_ACTIVE/PIX_PER_WORD
// PORTS
//  clk25175KHz   in   1       pixel clock, all logic on rising edge
//  reset         in   1       synchronous, active-high
//  hcount        in   10      pixel counter from timing generator (0..799)
//  vcount        in   10      line counter from timing generator (0..524)
//  cpu_req       in   1       CPU access request, held until cpu_ack
//  cpu_we        in   1       1 = write, 0 = read; stable while cpu_req
//  cpu_addr      in   ADDR_W  CPU word address; stable while cpu_req
//  cpu_wdata     in   DATA_W  CPU write data; stable while cpu_req
//  cpu_ack       out  1       one-cycle completion pulse
//  cpu_rdata     out  DATA_W  read data, valid while cpu_ack=1, otherwise 0
//  ram_en        out  1       RAM access strobe (combinational from arbiter)
//  ram_we        out  1       RAM write enable
//  ram_addr      out  ADDR_W  RAM word address
//  ram_wdata     out  DATA_W  RAM write data
//  ram_rdata     in   DATA_W  RAM read data, valid 1 cycle after ram_en
//  pixel_out     out  BPP     serialised pixel, 0 when pixel_valid=0
//  pixel_valid   out  1       pixel_out is a visible pixel
//  vblank_start  out  1       one-cycle pulse at hcount==0 && vcount==V_ACTIVE
// BEHAVIOUR
//  Reset: cpu_ack, cpu_rdata, pixel_out, pixel_valid, vblank_start = 0; FSM -> IDLE; ram_en = 0 in reset cycles.
//  Scanout slot: vcount<V_ACTIVE && hcount<H_ACTIVE && hcount%PIX_PER_WORD==0.
//   In a slot: ram_en=1, ram_we=0, ram_addr = vcount*(H_ACTIVE/PIX_PER_WORD) + hcount/PIX_PER_WORD.
//  Pixel pipeline: slot at cycle T; ram_rdata is loaded into the shifter at T+1.
//   Pixel k of the word is on pixel_out at T+2+k, k=0..PIX_PER_WORD-1.
//   Bits [BPP-1:0] hold the leftmost pixel. Column c is shown while hcount==c+2.
//   The timing generator delays its syncs by 2 to match.
//  CPU FSM, two states:
//   IDLE: cpu_req=1 and not a scanout slot -> grant: ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr,
//     ram_wdata=cpu_wdata; go to ACK.
//   IDLE: cpu_req=1 in a scanout slot -> no grant, stay IDLE (scanout wins).
//   ACK (the cycle after a grant): cpu_ack=1; cpu_rdata=ram_rdata for reads, 0 for writes; no grant; go to IDLE.
//  Handshake: requester drops or changes cpu_req/cpu_addr in the ACK cycle.
//   Max CPU rate is 1 access per 2 cycles. Grant latency is at most 2 cycles in active video.
//  Out-of-range (cpu_addr >= FB_WORDS): grant and ack timing unchanged.
//   Writes: ram_en/ram_we stay 0, data dropped. Reads: ram_en stays 0, cpu_rdata=0.
//  Blanking (hcount>=H_ACTIVE or vcount>=V_ACTIVE): no scanout slots; pixel_valid=0 except the pipeline tail at hcount 640/641.
//  Reset asserted mid-transaction (grant or ACK cycle): no cpu_ack is produced; FSM returns to IDLE.
//  ram_wdata = 0 when ram_we=0.
// TESTING
//  1. reset=1 for 5 cycles with cpu_req=1 -> cpu_ack, ram_en, pixel_valid, vblank_start all 0.
//  2. RAM[0]=8'b11_10_01_00; hcount=0, vcount=0 -> ram_en at hcount 0 with addr 0;
//     pixel_out=0,1,2,3 with pixel_valid=1 at hcount 2..5.
//  3. CPU write req at vcount=10, hcount=4 -> no grant at hcount 4 (scanout addr 1601);
//     grant at 5 with ram_we=1; cpu_ack at 6.
//  4. vcount=500, back-to-back reads of addr 7/8 holding 8'hA5/8'h3C -> grants every 2 cycles;
//     cpu_rdata = A5 then 3C in the ack cycles.
//  5. Write to addr 76800 -> cpu_ack after 1 cycle with ram_we=0; read of 76800 -> cpu_rdata=0.
//  6. reset asserted in a grant cycle -> no cpu_ack; next request completes normally;
//     vblank_start pulses once at (0,480) each frame.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout and a CPU req/ack port.
// Scanout slots always win the RAM; fetched words are serialised into pixels.
module vga_fb_arbiter #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BPP          = 2,
   parameter int PIX_PER_WORD = 4,
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = BPP * PIX_PER_WORD
) (
   input  logic              clk25175KHz,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [BPP-1:0]    pixel_out,
   output logic              pixel_valid,
   output logic              vblank_start
);
   localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;
   localparam int FB_WORDS       = WORDS_PER_LINE * V_ACTIVE;
   localparam int CNT_W          = $clog2(PIX_PER_WORD + 1);

   typedef enum logic {IDLE, ACK} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              r_ackRead;
   logic              w_nextAckRead;
   logic              r_load;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_pixLeft;
   logic              w_slot;
   logic              w_inRange;
   logic [ADDR_W-1:0] w_scanAddr;

   assign w_slot = (vcount < 10'(V_ACTIVE)) && (hcount < 10'(H_ACTIVE)) &&
                   ((hcount % 10'(PIX_PER_WORD)) == 10'd0);
   assign w_scanAddr = ADDR_W'(vcount) * ADDR_W'(WORDS_PER_LINE) +
                       ADDR_W'(hcount / 10'(PIX_PER_WORD));
   assign w_inRange  = ({1'b0, cpu_addr} < (ADDR_W + 1)'(FB_WORDS));

   always_ff @(posedge clk25175KHz) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ackRead <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_ackRead <= w_nextAckRead;
      end
   end

   // Scanout claims the RAM in its slot; otherwise an idle FSM grants the CPU.
   // Out-of-range CPU accesses still complete the handshake but never touch the RAM.
   always_comb begin
      w_nextState   = r_state;
      w_nextAckRead = 1'b0;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_addr      = '0;
      ram_wdata     = '0;
      cpu_ack       = 1'b0;
      cpu_rdata     = '0;
      if (!reset) begin
         if (w_slot) begin
            ram_en   = 1'b1;
            ram_addr = w_scanAddr;
         end
         case (r_state)
            IDLE: begin
               if (cpu_req && !w_slot) begin
                  w_nextState   = ACK;
                  w_nextAckRead = !cpu_we && w_inRange;
                  ram_en        = w_inRange;
                  ram_we        = cpu_we && w_inRange;
                  ram_addr      = cpu_addr;
                  ram_wdata     = (cpu_we && w_inRange) ? cpu_wdata : '0;
               end
            end
            ACK: begin
               cpu_ack     = 1'b1;
               cpu_rdata   = r_ackRead ? ram_rdata : '0;
               w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   // A word fetched in a slot is loaded one cycle later, then shifted out LSB-first.
   always_ff @(posedge clk25175KHz) begin
      if (reset) begin
         r_load    <= 1'b0;
         r_shift   <= '0;
         r_pixLeft <= '0;
      end else begin
         r_load <= w_slot;
         if (r_load) begin
            r_shift   <= ram_rdata;
            r_pixLeft <= CNT_W'(PIX_PER_WORD);
         end else if (r_pixLeft != '0) begin
            r_shift   <= r_shift >> BPP;
            r_pixLeft <= r_pixLeft - 1'b1;
         end
      end
   end

   assign pixel_valid  = (r_pixLeft != '0);
   assign pixel_out    = pixel_valid ? r_shift[BPP-1:0] : '0;
   assign vblank_start = !reset && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

endmodule
